exe_stage: RTL and testbench

//   Execute stage of the 5-stage ARM-subset pipeline. Sits directly downstream of the ID/EX register and consumes its outputs.

---
 rtl/exe_pkg.sv | 36 +++
 rtl/val2_gen.sv | 39 +++
 rtl/exe_stage.sv | 142 ++++++++++++++
 tb/tb_exe_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU commands, shift types, NZCV
// bit positions and forwarding-select codes.
package exe_pkg;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shiftType_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // An amount of 0 returns the value unchanged: v << 32 evaluates to zero.
  function automatic logic [31:0] rotateRight(input logic [31:0] v, input logic [4:0] amt);
    return (v >> amt) | (v << (6'd32 - {1'b0, amt}));
  endfunction

endpackage

// File: rtl/val2_gen.sv
// Operand-2 generator: rotated 8-bit immediate, 12-bit memory offset, or
// Rm shifted by an immediate amount. Purely combinational.
module val2_gen
  import exe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              imm,
  input  logic              memAccess,
  input  logic [11:0]       shiftOp,
  input  logic [DATA_W-1:0] rmVal,
  output logic [DATA_W-1:0] val2
);

  logic [4:0] shiftAmt;
  shiftType_t shiftType;

  assign shiftAmt  = shiftOp[11:7];
  assign shiftType = shiftType_t'(shiftOp[6:5]);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    val2 = '0;
    if (imm) begin
      val2 = rotateRight({{(DATA_W-8){1'b0}}, shiftOp[7:0]}, {shiftOp[11:8], 1'b0});
    end else if (memAccess) begin
      val2 = {{(DATA_W-12){1'b0}}, shiftOp};
    end else begin
      case (shiftType)
        SH_LSL:  val2 = rmVal << shiftAmt;
        SH_LSR:  val2 = rmVal >> shiftAmt;
        SH_ASR:  val2 = $signed(rmVal) >>> shiftAmt;
        SH_ROR:  val2 = rotateRight(rmVal, shiftAmt);
        default: val2 = rmVal;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, operand 2, ALU, branch target and the
// architectural NZCV register. Define FORWARDING_EN to enable the operand muxes.
module exe_stage
  import exe_pkg::*;
#(
  parameter int         DATA_W     = 32,
  parameter logic [3:0] STATUS_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        exe_cmd_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              wb_en_in,
  input  logic              s_in,
  input  logic              b_in,
  input  logic              carry_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] rn_val_in,
  input  logic [DATA_W-1:0] rm_val_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_op_in,
  input  logic [23:0]       signed_imm_in,
  input  logic [3:0]        dest_in,
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic [DATA_W-1:0] mem_alu_res,
  input  logic [DATA_W-1:0] wb_value,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] st_val,
  output logic [DATA_W-1:0] br_addr,
  output logic              br_taken,
  output logic [3:0]        status,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en,
  output logic [3:0]        dest
);

  logic [DATA_W-1:0] rnSrc;
  logic [DATA_W-1:0] rmSrc;
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] opB;
  logic [DATA_W:0]   addSum;
  logic [DATA_W-1:0] logicRes;
  logic [DATA_W-1:0] aluResult;
  logic [3:0]        nextStatus;
  logic [3:0]        statusReg;
  logic              isArith;
  logic              isLogic;
  logic              invertB;
  logic              addCin;

`ifdef FORWARDING_EN
  always_comb begin
    case (sel_src1)
      FWD_MEM: rnSrc = mem_alu_res;
      FWD_WB:  rnSrc = wb_value;
      default: rnSrc = rn_val_in;
    endcase
    case (sel_src2)
      FWD_MEM: rmSrc = mem_alu_res;
      FWD_WB:  rmSrc = wb_value;
      default: rmSrc = rm_val_in;
    endcase
  end
`else
  logic unusedFwd;
  assign rnSrc     = rn_val_in;
  assign rmSrc     = rm_val_in;
  assign unusedFwd = ^{sel_src1, sel_src2, mem_alu_res, wb_value};
`endif

  val2_gen #(.DATA_W(DATA_W)) u_val2_gen (
    .imm       (imm_in),
    .memAccess (mem_r_en_in | mem_w_en_in),
    .shiftOp   (shift_op_in),
    .rmVal     (rmSrc),
    .val2      (val2)
  );

  // Subtraction reuses the adder as Rn + ~val2 + cin, so the carry out is NOT borrow.
  always_comb begin
    isArith  = 1'b0;
    isLogic  = 1'b0;
    invertB  = 1'b0;
    addCin   = 1'b0;
    logicRes = '0;
    case (exe_cmd_in)
      EXE_MOV: begin isLogic = 1'b1; logicRes = val2;          end
      EXE_MVN: begin isLogic = 1'b1; logicRes = ~val2;         end
      EXE_AND: begin isLogic = 1'b1; logicRes = rnSrc & val2;  end
      EXE_ORR: begin isLogic = 1'b1; logicRes = rnSrc | val2;  end
      EXE_EOR: begin isLogic = 1'b1; logicRes = rnSrc ^ val2;  end
      EXE_ADD: begin isArith = 1'b1;                           end
      EXE_ADC: begin isArith = 1'b1; addCin = carry_in;        end
      EXE_SUB: begin isArith = 1'b1; invertB = 1'b1; addCin = 1'b1;     end
      EXE_SBC: begin isArith = 1'b1; invertB = 1'b1; addCin = carry_in; end
      default: ;
    endcase
  end

  assign opB    = invertB ? ~val2 : val2;
  assign addSum = {1'b0, rnSrc} + {1'b0, opB} + {{DATA_W{1'b0}}, addCin};

  always_comb begin
    aluResult  = '0;
    nextStatus = statusReg;
    if (isArith) begin
      aluResult          = addSum[DATA_W-1:0];
      nextStatus[FLAG_N] = aluResult[DATA_W-1];
      nextStatus[FLAG_Z] = (aluResult == '0);
      nextStatus[FLAG_C] = addSum[DATA_W];
      nextStatus[FLAG_V] = (rnSrc[DATA_W-1] == opB[DATA_W-1]) &&
                           (aluResult[DATA_W-1] != rnSrc[DATA_W-1]);
    end else if (isLogic) begin
      aluResult          = logicRes;
      nextStatus[FLAG_N] = aluResult[DATA_W-1];
      nextStatus[FLAG_Z] = (aluResult == '0);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      statusReg <= STATUS_RST;
    end else if (s_in) begin
      statusReg <= nextStatus;
    end
  end

  assign alu_res  = aluResult;
  assign st_val   = rmSrc;
  assign br_addr  = pc_in + {{6{signed_imm_in[23]}}, signed_imm_in, 2'b00};
  assign br_taken = b_in;
  assign status   = statusReg;
  assign mem_r_en = mem_r_en_in;
  assign mem_w_en = mem_w_en_in;
  assign wb_en    = wb_en_in;
  assign dest     = dest_in;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage; expected values queue up when each step is
// driven and are popped when outputs are sampled. Honours FORWARDING_EN.
module tb_exe_stage;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  exe_cmd_in;
  logic        mem_r_en_in, mem_w_en_in, wb_en_in, s_in, b_in, carry_in, imm_in;
  logic [31:0] pc_in, rn_val_in, rm_val_in, mem_alu_res, wb_value;
  logic [11:0] shift_op_in;
  logic [23:0] signed_imm_in;
  logic [3:0]  dest_in;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] alu_res, st_val, br_addr;
  logic        br_taken, mem_r_en, mem_w_en, wb_en;
  logic [3:0]  status, dest;

  typedef enum {SIG_ALU, SIG_ST, SIG_BR, SIG_TAKEN, SIG_MRD, SIG_MWR, SIG_WB, SIG_DEST} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t combQ[$];
  exp_t statQ[$];
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  exe_stage #(.DATA_W(32), .STATUS_RST(4'b0000)) dut (
    .clk(clk), .rst(rst), .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .s_in(s_in), .b_in(b_in),
    .carry_in(carry_in), .pc_in(pc_in), .rn_val_in(rn_val_in), .rm_val_in(rm_val_in),
    .imm_in(imm_in), .shift_op_in(shift_op_in), .signed_imm_in(signed_imm_in),
    .dest_in(dest_in), .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_alu_res(mem_alu_res), .wb_value(wb_value), .alu_res(alu_res),
    .st_val(st_val), .br_addr(br_addr), .br_taken(br_taken), .status(status),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .dest(dest)
  );

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      SIG_ALU:   return alu_res;
      SIG_ST:    return st_val;
      SIG_BR:    return br_addr;
      SIG_TAKEN: return {31'b0, br_taken};
      SIG_MRD:   return {31'b0, mem_r_en};
      SIG_MWR:   return {31'b0, mem_w_en};
      SIG_WB:    return {31'b0, wb_en};
      default:   return {28'b0, dest};
    endcase
  endfunction

  task automatic expectOut(input string tag, input sig_e sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.sig = sig; e.val = val;
    combQ.push_back(e);
  endtask

  task automatic expectStatus(input string tag, input logic [3:0] val);
    exp_t e;
    e.tag = tag; e.sig = SIG_ALU; e.val = {28'b0, val};
    statQ.push_back(e);
  endtask

  task automatic setDefaults();
    exe_cmd_in = 4'b0000; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; wb_en_in = 1'b0;
    s_in = 1'b0; b_in = 1'b0; carry_in = 1'b0; imm_in = 1'b0;
    pc_in = 32'h0; rn_val_in = 32'h0; rm_val_in = 32'h0;
    shift_op_in = 12'h0; signed_imm_in = 24'h0; dest_in = 4'h0;
    sel_src1 = 2'b00; sel_src2 = 2'b00;
    mem_alu_res = 32'hA5A5_0001; wb_value = 32'h5A5A_0002;
  endtask

  // Combinational outputs are checked on the falling edge, status just after the rising edge.
  task automatic cycle();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clk);
    while (combQ.size() > 0) begin
      e   = combQ.pop_front();
      obs = observe(e.sig);
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
    @(posedge clk);
    #1;
    while (statQ.size() > 0) begin
      e   = statQ.pop_front();
      obs = {28'b0, status};
      vectors++;
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    // Reset held two cycles with an S-type MOV 0 waiting behind it.
    setDefaults(); rst = 1'b1; exe_cmd_in = EXE_MOV; imm_in = 1'b1; s_in = 1'b1;
    expectOut("rst_alu", SIG_ALU, 32'h0); expectStatus("rst_st0", 4'b0000); cycle();
    expectStatus("rst_st1", 4'b0000); cycle();
    rst = 1'b0;
    expectStatus("rst_release", 4'b0100); cycle();

    setDefaults(); exe_cmd_in = EXE_ADD; rn_val_in = 32'h7FFF_FFFF; imm_in = 1'b1;
    shift_op_in = 12'h001; s_in = 1'b1;
    expectOut("add_ovf", SIG_ALU, 32'h8000_0000); expectStatus("add_nzcv", 4'b1001); cycle();

    setDefaults(); exe_cmd_in = EXE_SUB; rn_val_in = 32'd1; rm_val_in = 32'd2; s_in = 1'b1;
    expectOut("sub_borrow", SIG_ALU, 32'hFFFF_FFFF); expectStatus("sub_nzcv", 4'b1000); cycle();

    setDefaults(); exe_cmd_in = EXE_SUB; rn_val_in = 32'd5; rm_val_in = 32'd5; s_in = 1'b1;
    expectOut("cmp_eq", SIG_ALU, 32'h0); expectStatus("cmp_nzcv", 4'b0110); cycle();

    setDefaults(); exe_cmd_in = EXE_MOV; imm_in = 1'b1; shift_op_in = 12'h4FF;
    expectOut("imm_rot", SIG_ALU, 32'hFF00_0000); expectStatus("no_s_hold", 4'b0110); cycle();

    setDefaults(); exe_cmd_in = EXE_MOV; rm_val_in = 32'h8000_0000; shift_op_in = 12'h240;
    expectOut("asr4", SIG_ALU, 32'hF800_0000); cycle();

    setDefaults(); exe_cmd_in = EXE_MOV; rm_val_in = 32'h0000_0003; shift_op_in = 12'h200;
    expectOut("lsl4", SIG_ALU, 32'h0000_0030); cycle();

    setDefaults(); exe_cmd_in = EXE_MOV; rm_val_in = 32'h0000_0011; shift_op_in = 12'h260;
    expectOut("ror4", SIG_ALU, 32'h1000_0001); cycle();

    setDefaults(); exe_cmd_in = EXE_ADD; mem_r_en_in = 1'b1; wb_en_in = 1'b1; dest_in = 4'd9;
    rn_val_in = 32'h0000_1000; rm_val_in = 32'h0000_0003; shift_op_in = 12'hABC;
    expectOut("ldr_addr", SIG_ALU, 32'h0000_1ABC); expectOut("ldr_mrd", SIG_MRD, 32'd1);
    expectOut("ldr_wb", SIG_WB, 32'd1); expectOut("ldr_dest", SIG_DEST, 32'd9); cycle();

    setDefaults(); exe_cmd_in = EXE_ADD; mem_w_en_in = 1'b1; rn_val_in = 32'h0000_2000;
    rm_val_in = 32'hDEAD_BEEF; shift_op_in = 12'h010;
    expectOut("str_addr", SIG_ALU, 32'h0000_2010); expectOut("str_data", SIG_ST, 32'hDEAD_BEEF);
    expectOut("str_mwr", SIG_MWR, 32'd1); expectOut("str_mrd", SIG_MRD, 32'd0); cycle();

    setDefaults(); exe_cmd_in = EXE_AND; rn_val_in = 32'h0000_F0F0; imm_in = 1'b1; shift_op_in = 12'h0FF;
    expectOut("and", SIG_ALU, 32'h0000_00F0); cycle();

    setDefaults(); exe_cmd_in = EXE_ORR; rn_val_in = 32'h0000_0F00; imm_in = 1'b1; shift_op_in = 12'h00F;
    expectOut("orr", SIG_ALU, 32'h0000_0F0F); cycle();

    setDefaults(); exe_cmd_in = EXE_EOR; rn_val_in = 32'h0000_00FF; imm_in = 1'b1; shift_op_in = 12'h00F;
    expectOut("eor", SIG_ALU, 32'h0000_00F0); cycle();

    // Logic op with S keeps C=1, V=0 from the earlier CMP.
    setDefaults(); exe_cmd_in = EXE_MVN; imm_in = 1'b1; s_in = 1'b1;
    expectOut("mvn", SIG_ALU, 32'hFFFF_FFFF); expectStatus("mvn_keep_cv", 4'b1010); cycle();

    setDefaults(); exe_cmd_in = EXE_ADC; rn_val_in = 32'hFFFF_FFFF; imm_in = 1'b1; carry_in = 1'b1; s_in = 1'b1;
    expectOut("adc_wrap", SIG_ALU, 32'h0); expectStatus("adc_nzcv", 4'b0110); cycle();

    setDefaults(); exe_cmd_in = EXE_SBC; rn_val_in = 32'd5; imm_in = 1'b1; shift_op_in = 12'h002; s_in = 1'b1;
    expectOut("sbc", SIG_ALU, 32'd2); expectStatus("sbc_nzcv", 4'b0010); cycle();

    setDefaults(); exe_cmd_in = 4'b1111; rn_val_in = 32'd7; imm_in = 1'b1; shift_op_in = 12'h001; s_in = 1'b1;
    expectOut("bad_cmd", SIG_ALU, 32'h0); expectStatus("bad_cmd_hold", 4'b0010); cycle();

    setDefaults(); b_in = 1'b1; pc_in = 32'h0000_0100; signed_imm_in = 24'hFF_FFFE;
    expectOut("br_back", SIG_BR, 32'h0000_00F8); expectOut("br_taken", SIG_TAKEN, 32'd1);
    expectStatus("br_hold", 4'b0010); cycle();

    setDefaults(); pc_in = 32'hFFFF_FFF0; signed_imm_in = 24'h00_0008;
    expectOut("br_wrap", SIG_BR, 32'h0000_0010); expectOut("br_idle", SIG_TAKEN, 32'd0); cycle();

    setDefaults(); exe_cmd_in = EXE_ADD; sel_src1 = 2'b01; mem_alu_res = 32'd10; rn_val_in = 32'd3;
    imm_in = 1'b1; shift_op_in = 12'h001;
`ifdef FORWARDING_EN
    expectOut("fwd_mem_rn", SIG_ALU, 32'd11);
`else
    expectOut("fwd_mem_rn", SIG_ALU, 32'd4);
`endif
    cycle();

    setDefaults(); exe_cmd_in = EXE_MOV; sel_src2 = 2'b10; wb_value = 32'h0000_0055; rm_val_in = 32'd7;
`ifdef FORWARDING_EN
    expectOut("fwd_wb_rm", SIG_ALU, 32'h0000_0055); expectOut("fwd_wb_st", SIG_ST, 32'h0000_0055);
`else
    expectOut("fwd_wb_rm", SIG_ALU, 32'd7); expectOut("fwd_wb_st", SIG_ST, 32'd7);
`endif
    cycle();

    setDefaults(); exe_cmd_in = EXE_ADD; sel_src1 = 2'b11; rn_val_in = 32'd3; imm_in = 1'b1; shift_op_in = 12'h001;
    expectOut("fwd_sel11", SIG_ALU, 32'd4); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
